// File: rtl/sdram_mm_master.sv
// Single-beat Avalon-MM host for the SDRAM controller bridge with a credit-guarded read-response FIFO.
// Optional read-return watchdog is built when SDRAM_MM_TIMEOUT_EN is defined.
module sdram_mm_master #(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 32,
    parameter int RD_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_burstcount,
    output logic                m_debugaccess,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                err_unexp,
    output logic                err_timeout
);
    localparam int BE_W = DATA_W / 8;
    localparam int PW   = $clog2(RD_DEPTH);
    localparam int CW   = PW + 1;

    if ((RD_DEPTH < 2) || ((RD_DEPTH & (RD_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sdram_mm_master: RD_DEPTH must be a power of 2 >= 2");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("sdram_mm_master: TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    typedef enum logic {S_IDLE, S_CMD} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_writedata;
    logic [BE_W-1:0]   r_byteenable;
    logic              r_m_read;
    logic              r_m_write;
    logic [CW-1:0]     r_credits;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_fifo_cnt;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [DATA_W-1:0] r_mem [RD_DEPTH];
    logic              r_err_unexp;

    logic w_accept, w_rd_accept, w_pop, w_rd_done, w_push;

    assign req_ready     = (r_state == S_IDLE) && (r_credits < CW'(RD_DEPTH));
    assign w_accept      = req_valid & req_ready;
    assign w_rd_accept   = w_accept & ~req_we;
    assign w_pop         = resp_valid & resp_ready;
    assign w_rd_done     = (r_state == S_CMD) & ~m_waitrequest & r_m_read;
    assign w_push        = m_readdatavalid & (r_inflight != '0);

    assign m_address     = r_address;
    assign m_read        = r_m_read;
    assign m_write       = r_m_write;
    assign m_writedata   = r_writedata;
    assign m_byteenable  = r_byteenable;
    assign m_burstcount  = 1'b1;
    assign m_debugaccess = 1'b0;
    assign resp_valid    = (r_fifo_cnt != '0);
    assign resp_rdata    = r_mem[r_rptr];
    assign err_unexp     = r_err_unexp;

    // Command FSM: bus signals stay frozen in CMD until the agent releases waitrequest.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state      <= S_IDLE;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_m_read     <= 1'b0;
            r_m_write    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_address    <= req_addr;
                    r_writedata  <= req_wdata;
                    r_byteenable <= req_be;
                    r_m_read     <= ~req_we;
                    r_m_write    <= req_we;
                    r_state      <= S_CMD;
                end
                S_CMD: if (!m_waitrequest) begin
                    r_m_read  <= 1'b0;
                    r_m_write <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_credits   <= '0;
            r_inflight  <= '0;
            r_fifo_cnt  <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_err_unexp <= 1'b0;
        end else begin
            case ({w_rd_accept, w_pop})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: ;
            endcase
            case ({w_rd_done, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: ;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: ;
            endcase
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (m_readdatavalid && (r_inflight == '0)) r_err_unexp <= 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_push) r_mem[r_wptr] <= m_readdata;
    end

`ifdef SDRAM_MM_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_err_timeout;

    // Watchdog only observes; outstanding reads stay outstanding after it fires.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else if (m_readdatavalid || (r_inflight == '0)) begin
            r_to_cnt <= '0;
        end else begin
            if (r_to_cnt != 16'hFFFF) r_to_cnt <= r_to_cnt + 16'd1;
            if ({16'd0, r_to_cnt} + 32'd1 >= 32'(TIMEOUT_CYCLES)) r_err_timeout <= 1'b1;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_mm_master.sv
// Randomized + directed bench for sdram_mm_master; the bench plays both the core and the Avalon agent.
module tb_sdram_mm_master;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        req_valid, req_ready, req_we;
    logic [26:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [26:0] m_address;
    logic        m_read, m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_burstcount, m_debugaccess;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        err_unexp, err_timeout;

    sdram_mm_master dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_burstcount(m_burstcount), .m_debugaccess(m_debugaccess),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .err_unexp(err_unexp), .err_timeout(err_timeout)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct { int due; logic [31:0] data; } pend_t;

    // Reference model: transaction-level view of the core/agent contract.
    int          n_assert = 0, n_fail = 0;
    int          cyc = 0, last_due = 0, lat = 1;
    int          credits = 0, rd_hi = 0, wr_hi = 0;
    bit          busy = 0, cur_we = 0, last_acc = 0, exp_unexp = 0, force_rdv = 0;
    logic [26:0] cur_addr;
    logic [31:0] cur_wdata, ret_data;
    logic [3:0]  cur_be;
    logic [31:0] exp_q[$];
    pend_t       pend[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance the model to the next rising edge.
    task automatic step(input bit rv, input bit we, input logic [26:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input bit rr, input bit wr);
        bit rdv, pop;
        pend_t p;
        chk("req_ready", req_ready, !busy && credits < 4);
        chk("m_read", m_read, busy && !cur_we);
        chk("m_write", m_write, busy && cur_we);
        chk("rd_wr_exclusive", m_read & m_write, 0);
        if (busy) begin
            chk("m_address", m_address, cur_addr);
            chk("m_byteenable", m_byteenable, cur_be);
            if (cur_we) chk("m_writedata", m_writedata, cur_wdata);
        end
        chk("resp_valid", resp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("resp_rdata", resp_rdata, exp_q[0]);
        chk("m_burstcount", m_burstcount, 1);
        chk("m_debugaccess", m_debugaccess, 0);
        chk("err_unexp", err_unexp, exp_unexp);
        chk("err_timeout", err_timeout, 0);
        if (m_read)  rd_hi++;
        if (m_write) wr_hi++;

        req_valid = rv; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        resp_ready = rr; m_waitrequest = wr;
        rdv = (pend.size() != 0) && (pend[0].due <= cyc);
        m_readdatavalid = rdv || (force_rdv && pend.size() == 0);
        m_readdata = rdv ? pend[0].data : 32'hBADBAD00;

        last_acc = rv && !busy && credits < 4;
        pop = (exp_q.size() != 0) && rr;
        if (last_acc) begin
            busy = 1; cur_we = we; cur_addr = a; cur_wdata = wd; cur_be = be;
            if (!we) credits++;
        end else if (busy && !wr) begin
            busy = 0;
            if (!cur_we) begin
                p.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                p.data = ret_data;
                last_due = p.due;
                pend.push_back(p);
            end
        end
        if (pop) begin void'(exp_q.pop_front()); credits--; end
        if (rdv) begin exp_q.push_back(pend[0].data); void'(pend.pop_front()); end
        else if (m_readdatavalid) exp_unexp = 1;
        @(posedge clk_clk);
        cyc++;
        @(negedge clk_clk);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, rr, 0);
    endtask

    task automatic rd(input logic [26:0] a, input bit rr);
        step(1, 0, a, '0, 4'hF, rr, 0);
        step(0, 0, '0, '0, '0, rr, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (exp_q.size() != 0 || pend.size() != 0 || busy); k++)
            step(0, 0, '0, '0, '0, 1, 0);
        chk("drain_bound", exp_q.size() + pend.size() + int'(busy), 0);
    endtask

    initial begin
        reset_reset_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 0; m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;
        ret_data = '0;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_m_writedata", m_writedata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        reset_reset_n = 1;

        // Read held through 3 waitrequest cycles, data returns 2 cycles after completion.
        lat = 2; ret_data = 32'hDEADBEEF; rd_hi = 0;
        step(1, 0, 27'h0000100, '0, 4'hF, 0, 1);
        step(0, 0, '0, '0, '0, 0, 1);
        step(0, 0, '0, '0, '0, 0, 1);
        step(0, 0, '0, '0, '0, 0, 1);
        step(0, 0, '0, '0, '0, 0, 0);
        chk("read_hold_cycles", rd_hi, 4);
        idle(3, 0);
        chk("read_data", resp_rdata, 32'hDEADBEEF);
        idle(1, 1);
        chk("read_popped", resp_valid, 0);

        // Write with no wait: one cycle of m_write, no response.
        wr_hi = 0;
        step(1, 1, 27'h0000200, 32'h12345678, 4'b0011, 0, 0);
        step(0, 0, '0, '0, '0, 0, 0);
        idle(3, 0);
        chk("write_cycles", wr_hi, 1);
        chk("write_no_resp", resp_valid, 0);

        // Four reads fill the credits; the fifth waits until one response is popped.
        lat = 3;
        for (int i = 0; i < 4; i++) begin ret_data = 32'hA0 + i; rd(27'(i * 4), 0); end
        idle(6, 0);
        ret_data = 32'hA4;
        step(1, 0, 27'h40, '0, 4'hF, 0, 0);
        chk("fifth_blocked", last_acc, 0);
        step(1, 0, 27'h40, '0, 4'hF, 1, 0);
        chk("fifth_blocked_on_pop", last_acc, 0);
        step(1, 0, 27'h40, '0, 4'hF, 0, 0);
        chk("fifth_accepted", last_acc, 1);
        step(0, 0, '0, '0, '0, 0, 0);
        drain();

        // Accept and pop in one cycle must leave the credit count unchanged.
        for (int i = 0; i < 3; i++) begin ret_data = 32'hC0 + i; rd(27'(8 * i), 0); end
        idle(6, 0);
        ret_data = 32'hC3;
        step(1, 0, 27'h80, '0, 4'hF, 1, 0);
        chk("simul_accept", last_acc, 1);
        step(0, 0, '0, '0, '0, 0, 0);
        ret_data = 32'hC4;
        step(1, 0, 27'h84, '0, 4'hF, 0, 0);
        chk("credit_after_simul", last_acc, 1);
        step(0, 0, '0, '0, '0, 0, 0);
        step(1, 0, 27'h88, '0, 4'hF, 0, 0);
        chk("full_after_simul", last_acc, 0);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            ret_data = $urandom;
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 27'($urandom), $urandom,
                 4'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end
        drain();

        // Unexpected readdatavalid while idle.
        force_rdv = 1;
        idle(1, 0);
        force_rdv = 0;
        idle(1, 0);
        chk("unexp_flag", err_unexp, 1);
        chk("unexp_no_data", resp_valid, 0);

        // Reset in the middle of a held read.
        step(1, 0, 27'h300, '0, 4'hF, 0, 1);
        step(0, 0, '0, '0, '0, 0, 1);
        reset_reset_n = 0;
        @(posedge clk_clk);
        @(negedge clk_clk);
        chk("rst_mid_m_read", m_read, 0);
        chk("rst_mid_err_unexp", err_unexp, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        reset_reset_n = 1;
        busy = 0; credits = 0; exp_unexp = 0; exp_q.delete(); pend.delete();
        lat = 1; ret_data = 32'h5A5A5A5A;
        rd(27'h304, 0);
        idle(3, 0);
        chk("post_rst_read", resp_rdata, 32'h5A5A5A5A);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
